// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller.
// Holds FSM states, RISC-V funct3 codes, memory port access types and decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b011;
    localparam logic [2:0] MT_HU = 3'b100;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Access size minus one; doubles as the alignment mask for the low address bits.
    function automatic logic [1:0] f3_size_m1(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Loads always fetch raw (unsigned) data; extension happens locally.
    function automatic logic [2:0] load_mem_type(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MT_BU;
            2'b01:   return MT_HU;
            default: return MT_W;
        endcase
    endfunction

    function automatic logic [2:0] store_mem_type(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MT_B;
            2'b01:   return MT_H;
            default: return MT_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of raw little-endian load data according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_c_o
);

    always_comb begin
        ext_c_o = '0;
        case (funct3_i)
            F3_B:    ext_c_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    ext_c_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_W:    ext_c_o = raw_i;
            F3_BU:   ext_c_o = {24'h0, raw_i[7:0]};
            F3_HU:   ext_c_o = {16'h0, raw_i[15:0]};
            default: ext_c_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: aligned accesses go out in one memory cycle, misaligned
// half/word accesses are split into byte accesses and reassembled locally.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [2:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned AW1 = ADDR_W + 1;

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       cap_q, cap_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        mem_type_q, mem_type_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic [1:0]        req_size_m1;
    logic [AW1-1:0]    req_last_addr;
    logic              req_oob;
    logic              req_aligned;
    logic [1:0]        cnt_nx;
    logic [31:0]       ext_data;

    assign accept        = req_valid && req_ready_q;
    assign req_size_m1   = f3_size_m1(req_funct3);
    // Extra top bit keeps addresses near the top of the space from wrapping into range.
    assign req_last_addr = {1'b0, req_addr} + AW1'(req_size_m1);
    assign req_oob       = req_last_addr >= AW1'(MEM_BYTES);
    assign req_aligned   = (req_addr[1:0] & req_size_m1) == 2'b00;
    assign cnt_nx        = cnt_q + 2'd1;

    // Capture buffer for load data returned by the memory this cycle.
    always_comb begin
        cap_d = cap_q;
        case (state_q)
            IDLE:    if (accept) cap_d = '0;
            ACCESS:  if (!we_q) cap_d = mem_rdata;
            SPLIT:   if (!we_q) cap_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
            default: cap_d = cap_q;
        endcase
    end

    lsu_load_ext u_load_ext (
        .raw_i    (cap_d),
        .funct3_i (f3_q),
        .ext_c_o  (ext_data)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        mem_type_d   = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    if (!f3_legal(req_we, req_funct3) || req_oob) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_aligned) begin
                        state_d     = ACCESS;
                        rd_en_d     = !req_we;
                        wr_en_d     = req_we;
                        mem_addr_d  = req_addr;
                        mem_type_d  = req_we ? store_mem_type(req_funct3)
                                             : load_mem_type(req_funct3);
                        mem_wdata_d = req_we ? req_wdata : 32'h0;
                    end else begin
                        state_d     = SPLIT;
                        rd_en_d     = !req_we;
                        wr_en_d     = req_we;
                        mem_addr_d  = req_addr;
                        mem_type_d  = req_we ? MT_B : MT_BU;
                        mem_wdata_d = req_we ? {24'h0, req_wdata[7:0]} : 32'h0;
                    end
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'h0 : ext_data;
            end
            SPLIT: begin
                if (cnt_q == f3_size_m1(f3_q)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0 : ext_data;
                end else begin
                    cnt_d       = cnt_nx;
                    rd_en_d     = !we_q;
                    wr_en_d     = we_q;
                    mem_addr_d  = addr_q + ADDR_W'(cnt_nx);
                    mem_type_d  = we_q ? MT_B : MT_BU;
                    mem_wdata_d = we_q ? {24'h0, wdata_q[{cnt_nx, 3'b000} +: 8]} : 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cap_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            mem_type_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            mem_type_q   <= mem_type_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_wr_en  = wr_en_q;
    assign mem_type   = mem_type_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 128-byte behavioural data memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    logic preload = 1'b1;
    logic both_seen = 1'b0;

    logic [7:0] mem [0:127];
    logic [7:0] init_b [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h85, 8'h96, 8'hA7, 8'hB8};

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .MEM_BYTES(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_type   (mem_type),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural memory: combinational read, write on the rising edge.
    logic [6:0] ma;
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        ma = mem_addr[6:0];
        b0 = mem[ma];
        b1 = mem[ma + 7'd1];
        b2 = mem[ma + 7'd2];
        b3 = mem[ma + 7'd3];
        case (mem_type)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b011:  mem_rdata = {24'h0, b0};
            3'b100:  mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= (i < 8) ? init_b[i] : 8'h00;
        end else if (mem_wr_en) begin
            mem[ma] <= mem_wdata[7:0];
            if (mem_type == 3'b001 || mem_type == 3'b010) mem[ma + 7'd1] <= mem_wdata[15:8];
            if (mem_type == 3'b010) begin
                mem[ma + 7'd2] <= mem_wdata[23:16];
                mem[ma + 7'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) both_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Presents one request; returns at the negedge of the first cycle after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b want 1", req_ready); end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload = 1'b1;
        step(3);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL rst_enables: got %b want 00", {mem_rd_en, mem_wr_en}); end
        checks++; if (mem_type !== 3'b000) begin errors++; $display("FAIL rst_mem_type: got %b want 000", mem_type); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0;
        preload = 1'b0;
        step(1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_aligned_load();
        issue(1'b0, 3'b010, 32'd0, 32'h0);
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL lw_rd_en: got %b want 1", mem_rd_en); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL lw_wr_en: got %b want 0", mem_wr_en); end
        checks++; if (mem_type !== 3'b010) begin errors++; $display("FAIL lw_type: got %b want 010", mem_type); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL lw_addr: got %h want 0", mem_addr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lw_busy: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_early_resp: got %b want 0", resp_valid); end
        step(1);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lw_resp_valid: got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'h44332211) begin errors++; $display("FAIL lw_rdata: got %h want 44332211", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", resp_err); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL lw_resp_rd_en: got %b want 0", mem_rd_en); end
        step(1);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse: got %b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_misaligned_half();
        issue(1'b0, 3'b001, 32'd5, 32'h0);
        checks++; if ({mem_rd_en, mem_type, mem_addr} !== {1'b1, 3'b011, 32'd5}) begin errors++; $display("FAIL lh5_c1: got rd=%b type=%b addr=%h want rd=1 type=011 addr=5", mem_rd_en, mem_type, mem_addr); end
        step(1);
        checks++; if ({mem_rd_en, mem_type, mem_addr} !== {1'b1, 3'b011, 32'd6}) begin errors++; $display("FAIL lh5_c2: got rd=%b type=%b addr=%h want rd=1 type=011 addr=6", mem_rd_en, mem_type, mem_addr); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lh5_early_resp: got %b want 0", resp_valid); end
        step(1);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lh5_resp_valid: got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hFFFFA796) begin errors++; $display("FAIL lh5_rdata: got %h want ffffa796", resp_rdata); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL lh5_resp_rd_en: got %b want 0", mem_rd_en); end
    endtask

    task automatic test_aligned_variants();
        logic [2:0]  f3s  [0:5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b101};
        logic [31:0] adrs [0:5] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd2, 32'd6};
        logic [31:0] exps [0:5] = '{32'hFFFFFF85, 32'h00000085, 32'h00009685,
                                    32'hFFFF9685, 32'h00000033, 32'h0000B8A7};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0);
            step(1);
            checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, exps[i]}) begin errors++; $display("FAIL load_var%0d: got v=%b e=%b d=%h want v=1 e=0 d=%h", i, resp_valid, resp_err, resp_rdata, exps[i]); end
        end
    endtask

    task automatic test_split_store();
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        issue(1'b1, 3'b010, 32'd1, wd);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({mem_wr_en, mem_rd_en, mem_type, mem_addr, mem_wdata[7:0], resp_valid} !== {1'b1, 1'b0, 3'b000, 32'd1 + 32'(i), wd[8*i +: 8], 1'b0}) begin errors++; $display("FAIL sw1_byte%0d: got wr=%b rd=%b type=%b addr=%h wd=%h rv=%b want wr=1 rd=0 type=000 addr=%0d wd=%h rv=0", i, mem_wr_en, mem_rd_en, mem_type, mem_addr, mem_wdata[7:0], resp_valid, i + 1, wd[8*i +: 8]); end
            step(1);
        end
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sw1_resp: got v=%b e=%b d=%h want v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); end
        checks++; if ({mem[4], mem[3], mem[2], mem[1]} !== 32'hDEADBEEF) begin errors++; $display("FAIL sw1_mem: got %h want deadbeef", {mem[4], mem[3], mem[2], mem[1]}); end
        issue(1'b0, 3'b010, 32'd1, 32'h0);
        step(3);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw1_early_resp: got %b want 0", resp_valid); end
        step(1);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw1_resp: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef", resp_valid, resp_err, resp_rdata); end
    endtask

    task automatic test_errors();
        logic        wes  [0:7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [0:7] = '{3'b011, 3'b111, 3'b011, 3'b110, 3'b010, 3'b001, 3'b001, 3'b000};
        logic [31:0] adrs [0:7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd126, 32'd127, 32'hFFFFFFFF, 32'd128};
        for (int i = 0; i < 8; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF);
            checks++; if ({resp_valid, resp_err, resp_rdata, mem_rd_en, mem_wr_en} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL err%0d: got v=%b e=%b d=%h rd=%b wr=%b want v=1 e=1 d=0 rd=0 wr=0", i, resp_valid, resp_err, resp_rdata, mem_rd_en, mem_wr_en); end
        end
        issue(1'b0, 3'b000, 32'd127, 32'h0);
        step(1);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL lb127_ok: got v=%b e=%b d=%h want v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); end
        issue(1'b0, 3'b101, 32'd126, 32'h0);
        step(1);
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL lhu126_ok: got v=%b e=%b want v=1 e=0", resp_valid, resp_err); end
    endtask

    task automatic test_reset_mid_split();
        issue(1'b1, 3'b010, 32'd9, 32'h11223344);
        step(2);
        checks++; if ({mem_wr_en, mem_addr} !== {1'b1, 32'd11}) begin errors++; $display("FAIL rsplit_c3: got wr=%b addr=%h want wr=1 addr=b", mem_wr_en, mem_addr); end
        rst = 1'b1;
        step(1);
        checks++; if ({req_ready, mem_rd_en, mem_wr_en, resp_valid} !== 4'b1000) begin errors++; $display("FAIL rsplit_idle: got rdy=%b rd=%b wr=%b rv=%b want 1000", req_ready, mem_rd_en, mem_wr_en, resp_valid); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if ({resp_valid, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL rsplit_quiet%0d: got rv=%b wr=%b want 00", i, resp_valid, mem_wr_en); end
        end
        checks++; if ({mem[12], mem[11], mem[10], mem[9]} !== 32'h00223344) begin errors++; $display("FAIL rsplit_mem: got %h want 00223344", {mem[12], mem[11], mem[10], mem[9]}); end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy, exp_rv;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_rdy = (k % 3) == 0;
            exp_rv  = (k % 3) == 2;
            checks++; if ({req_ready, resp_valid} !== {exp_rdy, exp_rv}) begin errors++; $display("FAIL b2b_cycle%0d: got rdy=%b rv=%b want rdy=%b rv=%b", k, req_ready, resp_valid, exp_rdy, exp_rv); end
            if (exp_rv) begin
                checks++; if (resp_rdata !== 32'h00000011) begin errors++; $display("FAIL b2b_rdata%0d: got %h want 00000011", k, resp_rdata); end
            end
        end
        req_valid = 1'b0;
        step(3);
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_misaligned_half();
        test_aligned_variants();
        test_split_store();
        test_errors();
        test_reset_mid_split();
        test_back_to_back();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL rd_wr_exclusive: got %b want 0", both_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
